// File: rtl/nibble_bus_pkg.sv
// Shared types and constants for the nibble-bus responder.
// Cycle-type decode, checker states and error codes.
package nibble_bus_pkg;

  localparam int NIB_W = 4;

  localparam logic [3:0] CTL_LOAD  = 4'b0111;
  localparam logic [3:0] CTL_STORE = 4'b0011;

  typedef enum logic [2:0] {
    CYC_F1,
    CYC_F2,
    CYC_F3,
    CYC_LOAD,
    CYC_STORE,
    CYC_ILL
  } cyc_t;

  typedef enum logic [1:0] {
    EXP_F1,
    EXP_F2,
    EXP_F3,
    EXP_POST
  } chk_state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ORDER = 3'd1;
  localparam logic [2:0] ERR_PC    = 3'd2;
  localparam logic [2:0] ERR_ILL   = 3'd3;
  localparam logic [2:0] ERR_DADDR = 3'd4;
  localparam logic [2:0] ERR_RANGE = 3'd5;

  // Map the {a1,a0,p1,p0} field onto a cycle type.
  function automatic cyc_t decode_cyc(input logic [3:0] ctl);
    cyc_t k;
    k = CYC_ILL;
    unique case (1'b1)
      (ctl[1:0] == 2'b00): k = CYC_F1;
      (ctl[1:0] == 2'b01): k = CYC_F2;
      (ctl[1:0] == 2'b10): k = CYC_F3;
      (ctl == CTL_LOAD):   k = CYC_LOAD;
      (ctl == CTL_STORE):  k = CYC_STORE;
      default:             k = CYC_ILL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/nibble_bus_seq_checker.sv
// Bus cycle-sequence checker with sticky first-error latch.
// Optional retired-instruction counter under RESP_ICOUNT_EN.
module nibble_bus_seq_checker
  import nibble_bus_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  cyc_t            kind,
  input  logic [PC_W-1:0] pc,
  input  logic            pc_oob,
  input  logic            addr_hi,
  input  logic            err_clr,
  output logic            proto_err,
  output logic [2:0]      err_code,
  output logic [15:0]     icount
);

  chk_state_t      state;
  chk_state_t      state_next;
  logic [PC_W-1:0] pc_q;
  logic            e_ord;
  logic            e_pc;
  logic            e_ill;
  logic            e_da;
  logic            e_rng;
  logic            any_err;
  logic [2:0]      code;

  // State register; every F1 captures the instruction PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EXP_F1;
      pc_q  <= '0;
    end else begin
      state <= state_next;
      if (kind == CYC_F1) pc_q <= pc;
    end
  end

  // Expected-phase check, next state and lowest-code priority.
  always_comb begin
    state_next = state;
    e_ord      = 1'b0;
    e_pc       = 1'b0;
    e_ill      = 1'b0;
    e_da       = 1'b0;
    e_rng      = 1'b0;
    unique case (kind)
      CYC_F1: begin
        e_ord      = (state != EXP_F1) && (state != EXP_POST);
        e_rng      = pc_oob;
        state_next = EXP_F2;
      end
      CYC_F2: begin
        e_ord      = (state != EXP_F2);
        e_pc       = (state == EXP_F2) && (pc != pc_q);
        e_rng      = pc_oob;
        state_next = EXP_F3;
      end
      CYC_F3: begin
        e_ord      = (state != EXP_F3);
        e_pc       = (state == EXP_F3) && (pc != pc_q);
        e_rng      = pc_oob;
        state_next = EXP_POST;
      end
      CYC_LOAD, CYC_STORE: begin
        e_ord      = (state != EXP_POST);
        e_da       = addr_hi;
        state_next = EXP_F1;
      end
      default: begin
        e_ill      = 1'b1;
        state_next = EXP_F1;
      end
    endcase
    any_err = e_ord | e_pc | e_ill | e_da | e_rng;
    // A broken sequence waits for the next F1 to resync.
    if (any_err && (kind != CYC_F1)) state_next = EXP_F1;
    if (e_ord)      code = ERR_ORDER;
    else if (e_pc)  code = ERR_PC;
    else if (e_ill) code = ERR_ILL;
    else if (e_da)  code = ERR_DADDR;
    else if (e_rng) code = ERR_RANGE;
    else            code = ERR_NONE;
  end

  // Keep the first error; a fresh error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (any_err && (!proto_err || err_clr)) begin
      proto_err <= 1'b1;
      err_code  <= code;
    end else if (err_clr) begin
      proto_err <= 1'b0;
      err_code  <= ERR_NONE;
    end
  end

`ifdef RESP_ICOUNT_EN
  logic        f3_ok;
  logic [15:0] icnt_q;

  assign f3_ok = (kind == CYC_F3) && !any_err;

  // Saturating count of cleanly accepted F3 phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      icnt_q <= '0;
    end else if (f3_ok && (icnt_q != 16'hFFFF)) begin
      icnt_q <= icnt_q + 16'd1;
    end
  end

  assign icount = icnt_q;
`else
  assign icount = '0;
`endif

endmodule

// File: rtl/nibble_bus_responder.sv
// Memory-side responder for the nibble-bus CPU tile.
// Define RESP_ICOUNT_EN to enable the retired-instruction counter.
module nibble_bus_responder
  import nibble_bus_pkg::*;
#(
  parameter int PROG_DEPTH = 64,
  parameter int DATA_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bus_addr_in,
  input  logic [3:0]  bus_ctl_in,
  input  logic [3:0]  bus_data_in,
  output logic [3:0]  bus_data_out,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [3:0]  prog_data,
  input  logic [3:0]  dbg_addr,
  output logic [3:0]  dbg_data,
  input  logic        err_clr,
  output logic        proto_err,
  output logic [2:0]  err_code,
  output logic [15:0] icount
);

  localparam int NIBS = 3 * PROG_DEPTH;
  localparam int PA_W = $clog2(NIBS);

  logic [NIB_W-1:0] prog_mem [NIBS];
  logic [NIB_W-1:0] data_mem [DATA_DEPTH];

  cyc_t            kind;
  logic [9:0]      pc;
  logic [PA_W-1:0] idx;
  logic            pc_oob;

  assign kind   = decode_cyc(bus_ctl_in);
  assign pc     = {bus_addr_in, bus_ctl_in[3:2]};
  assign pc_oob = 32'(pc) >= 32'(PROG_DEPTH);
  // Only used when pc is in range, so the truncation is exact.
  assign idx    = PA_W'(12'(pc) * 12'd3 + 12'(bus_ctl_in[1:0]));

  // Host program load; writes past the array are dropped.
  always_ff @(posedge clk) begin
    if (prog_we && (32'(prog_addr) < 32'(NIBS))) begin
      prog_mem[prog_addr[PA_W-1:0]] <= prog_data;
    end
  end

  // Data memory: cleared on reset, written by STORE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DATA_DEPTH; i++) data_mem[i] <= '0;
    end else if (kind == CYC_STORE) begin
      data_mem[bus_addr_in[3:0]] <= bus_data_in;
    end
  end

  // Zero-latency read path back to the CPU.
  always_comb begin
    bus_data_out = '0;
    unique case (kind)
      CYC_F1, CYC_F2, CYC_F3: begin
        if (!pc_oob) bus_data_out = prog_mem[idx];
      end
      CYC_LOAD: bus_data_out = data_mem[bus_addr_in[3:0]];
      default: ;
    endcase
  end

  assign dbg_data = data_mem[dbg_addr];

  nibble_bus_seq_checker #(
    .PC_W(10)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .kind     (kind),
    .pc       (pc),
    .pc_oob   (pc_oob),
    .addr_hi  (|bus_addr_in[7:4]),
    .err_clr  (err_clr),
    .proto_err(proto_err),
    .err_code (err_code),
    .icount   (icount)
  );

endmodule
